// File: rtl/tournament_predictor.sv
// Tournament branch predictor: bimodal + gshare tables with a per-PC chooser,
// combinational fetch-time prediction and single-cycle training from resolution.
module tournament_predictor #(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_valid,
  input  logic [31:0]         fetch_pc,
  output logic                predict1,
  output logic                predict2,
  output logic                pprediction,
  output logic [IDX_BITS-1:0] fetch_gidx,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [IDX_BITS-1:0] upd_gidx,
  input  logic                upd_taken,
  input  logic                taken1,
  input  logic                taken2,
  input  logic                upd_true,
  output logic [31:0]         branch_cnt,
  output logic [31:0]         correct_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          bim_q [ENTRIES];
  logic [1:0]          gsh_q [ENTRIES];
  logic [1:0]          cho_q [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         branch_cnt_q, branch_cnt_d;
  logic [31:0]         correct_cnt_q, correct_cnt_d;
  logic [1:0]          bim_d, gsh_d, cho_d;

  logic [IDX_BITS-1:0] fetch_pidx, upd_pidx, gidx;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic inc, input logic dec);
    if (inc && c != 2'b11) return c + 2'b01;
    if (dec && c != 2'b00) return c - 2'b01;
    return c;
  endfunction

  assign fetch_pidx = fetch_pc[IDX_BITS+1:2];
  assign upd_pidx   = upd_pc[IDX_BITS+1:2];
  assign gidx       = fetch_pidx ^ IDX_BITS'(ghr_q);

  always_comb begin
    predict1    = fetch_valid & bim_q[fetch_pidx][1];
    predict2    = fetch_valid & gsh_q[gidx][1];
    pprediction = cho_q[fetch_pidx][1] ? predict2 : predict1;
    fetch_gidx  = gidx;
  end

  // Next values for the single entry of each table touched by this update.
  always_comb begin
    bim_d         = ctr_next(bim_q[upd_pidx], upd_taken, ~upd_taken);
    gsh_d         = ctr_next(gsh_q[upd_gidx], upd_taken, ~upd_taken);
    cho_d         = ctr_next(cho_q[upd_pidx], taken2 & ~taken1, taken1 & ~taken2);
    ghr_d         = {ghr_q[GHR_BITS-2:0], upd_taken};
    branch_cnt_d  = branch_cnt_q + 32'd1;
    correct_cnt_d = correct_cnt_q + {31'd0, upd_true};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bim_q[i] <= 2'b01;
        gsh_q[i] <= 2'b01;
        cho_q[i] <= 2'b01;
      end
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      correct_cnt_q <= '0;
    end else if (upd_valid) begin
      bim_q[upd_pidx] <= bim_d;
      gsh_q[upd_gidx] <= gsh_d;
      cho_q[upd_pidx] <= cho_d;
      ghr_q           <= ghr_d;
      branch_cnt_q    <= branch_cnt_d;
      correct_cnt_q   <= correct_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign correct_cnt = correct_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

endmodule

// File: tb/tb_tournament_predictor.sv
// Self-checking bench for tournament_predictor: table-driven vectors with a
// scoreboard queue of expected fetch outputs and statistics, plus reset sequences.
module tb_tournament_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        predict1, predict2, pprediction;
  logic [5:0]  fetch_gidx;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [5:0]  upd_gidx;
  logic        upd_taken, taken1, taken2, upd_true;
  logic [31:0] branch_cnt, correct_cnt;

  tournament_predictor #(.IDX_BITS(6), .GHR_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .predict1(predict1), .predict2(predict2), .pprediction(pprediction),
    .fetch_gidx(fetch_gidx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_gidx(upd_gidx),
    .upd_taken(upd_taken), .taken1(taken1), .taken2(taken2), .upd_true(upd_true),
    .branch_cnt(branch_cnt), .correct_cnt(correct_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p1, p2, pp;
    logic [5:0]  gidx;
    logic [31:0] bc, cc;
  } exp_t;

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic [5:0]  ugidx;
    logic        ut, t1, t2, utr;
    logic        p1, p2, pp;
    logic [5:0]  gidx;
    logic [31:0] bc, cc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic p1, input logic p2, input logic pp,
                          input logic [5:0] gidx, input logic [31:0] bc, input logic [31:0] cc);
    exp_t e;
    e.p1 = p1; e.p2 = p2; e.pp = pp; e.gidx = gidx; e.bc = bc; e.cc = cc;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      cmp({tag, ".predict1"},    {31'd0, predict1},    {31'd0, e.p1});
      cmp({tag, ".predict2"},    {31'd0, predict2},    {31'd0, e.p2});
      cmp({tag, ".pprediction"}, {31'd0, pprediction}, {31'd0, e.pp});
      cmp({tag, ".fetch_gidx"},  {26'd0, fetch_gidx},  {26'd0, e.gidx});
      cmp({tag, ".branch_cnt"},  branch_cnt,           e.bc);
      cmp({tag, ".correct_cnt"}, correct_cnt,          e.cc);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic uv,
                       input logic [31:0] upc, input logic [5:0] ug, input logic ut,
                       input logic t1, input logic t2, input logic tr);
    fetch_valid = fv; fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_gidx = ug;
    upd_taken = ut; taken1 = t1; taken2 = t2; upd_true = tr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           fv fpc        uv upc        ug  ut t1 t2 tr  p1 p2 pp gidx bc cc
    vecs[0]  = '{1, 32'h10C, 0, 32'h10C,  0, 0, 0, 0, 0,  0, 0, 0,  3,  0, 0};
    vecs[1]  = '{1, 32'h10C, 1, 32'h10C,  3, 1, 0, 0, 0,  0, 0, 0,  3,  0, 0};
    vecs[2]  = '{1, 32'h10C, 1, 32'h10C,  3, 1, 0, 0, 0,  1, 0, 1,  2,  1, 0};
    vecs[3]  = '{1, 32'h10C, 0, 32'h10C,  0, 0, 0, 0, 0,  1, 0, 1,  0,  2, 0};
    vecs[4]  = '{1, 32'h10C, 1, 32'h10C,  0, 1, 0, 1, 1,  1, 0, 1,  0,  2, 0};
    vecs[5]  = '{1, 32'h10C, 1, 32'h10C,  4, 1, 0, 1, 1,  1, 0, 0,  4,  3, 1};
    vecs[6]  = '{1, 32'h10C, 1, 32'h10C, 12, 1, 1, 1, 1,  1, 0, 0, 12,  4, 2};
    vecs[7]  = '{1, 32'h10C, 1, 32'h10C, 28, 1, 1, 0, 0,  1, 0, 0, 28,  5, 3};
    vecs[8]  = '{1, 32'h10C, 1, 32'h10C,  5, 1, 1, 0, 0,  1, 0, 0, 60,  6, 3};
    vecs[9]  = '{1, 32'h10C, 0, 32'h10C,  0, 0, 0, 0, 0,  1, 0, 1, 60,  7, 3};
    vecs[10] = '{1, 32'h10C, 1, 32'h10C, 60, 0, 0, 0, 1,  1, 0, 1, 60,  7, 3};
    vecs[11] = '{1, 32'h10C, 1, 32'h10C, 61, 0, 0, 0, 1,  1, 0, 1, 61,  8, 4};
    vecs[12] = '{1, 32'h10C, 1, 32'h10C, 63, 0, 0, 0, 1,  0, 0, 0, 63,  9, 5};
    vecs[13] = '{1, 32'h10C, 1, 32'h10C, 59, 0, 0, 0, 0,  0, 0, 0, 59, 10, 6};
    vecs[14] = '{1, 32'h10C, 1, 32'h10C,  0, 1, 0, 0, 0,  0, 0, 0, 51, 11, 6};
    // fetch and update hit bim[3] together: fetch must see the old counter
    vecs[15] = '{1, 32'h10C, 1, 32'h10C, 34, 1, 0, 0, 1,  0, 0, 0, 34, 12, 6};
    vecs[16] = '{1, 32'h10C, 0, 32'h10C,  0, 0, 0, 0, 0,  1, 1, 1,  0, 13, 7};
    vecs[17] = '{0, 32'h10C, 0, 32'h10C,  0, 1, 0, 1, 1,  0, 0, 0,  0, 13, 7};
    vecs[18] = '{1, 32'h10C, 0, 32'h10C,  0, 0, 0, 0, 0,  1, 1, 1,  0, 13, 7};
    vecs[19] = '{1, 32'h200, 0, 32'h10C,  0, 0, 0, 0, 0,  0, 1, 0,  3, 13, 7};

    rst_n = 1'b0;
    drive(1, 32'h10C, 0, 32'h0, 6'd0, 0, 0, 0, 0);
    #12;
    push_exp(0, 0, 0, 6'd3, 0, 0);
    pop_check("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].fv, vecs[i].fpc, vecs[i].uv, vecs[i].upc, vecs[i].ugidx,
            vecs[i].ut, vecs[i].t1, vecs[i].t2, vecs[i].utr);
      push_exp(vecs[i].p1, vecs[i].p2, vecs[i].pp, vecs[i].gidx, vecs[i].bc, vecs[i].cc);
      @(negedge clk);
      pop_check($sformatf("vec%0d", i));
    end

    // Mid-operation async reset with an update pending: state clears at once,
    // and the pending update is discarded.
    @(posedge clk);
    #1;
    drive(1, 32'h10C, 1, 32'h10C, 6'd3, 1, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0, 6'd3, 0, 0);
    pop_check("async_rst_a");
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(0, 0, 0, 6'd3, 0, 0);
    pop_check("after_rst_a");

    // Statistics: three updates with upd_true = 1, 0, 1.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      case (k)
        0: drive(1, 32'h10C, 1, 32'h10C, 6'd3, 1, 1, 1, 1);
        1: drive(1, 32'h10C, 1, 32'h10C, 6'd2, 1, 1, 1, 0);
        default: drive(1, 32'h10C, 1, 32'h10C, 6'd0, 1, 1, 1, 1);
      endcase
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    push_exp(1, 0, 1, 6'd4, 3, 2);
    @(negedge clk);
    pop_check("stats");

    #2;
    rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0, 6'd3, 0, 0);
    pop_check("async_rst_b");
    @(negedge clk);
    rst_n = 1'b1;

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tournament_predictor.md
# tournament_predictor

Tournament branch predictor for the RISC-V core. At fetch it reads a bimodal table (predictor 1), a gshare table (predictor 2) and a per-PC chooser, and drives predict1, predict2 and the selected pprediction. These travel down the pipeline to the branch-resolution checker. The checker returns per-predictor correctness (taken1, taken2), final-prediction correctness (true) and the actual outcome (PCsel), and this block consumes them to train its tables, history and statistics.

## Interface
- IDX_BITS, 6: log2 of entries in each table (64 entries of 2-bit counters).
- GHR_BITS, 6: global history length; must be ≤ IDX_BITS.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  fetch-stage PC is valid.
- fetch_pc  in  32  fetch-stage PC.
- predict1  out  1  bimodal prediction (1 = taken).
- predict2  out  1  gshare prediction.
- pprediction  out  1  chooser-selected prediction.
- fetch_gidx  out  IDX_BITS  gshare index used for this fetch; carried down the pipeline.
- upd_valid  in  1  a resolved conditional branch (opcode 1100011) is presented.
- upd_pc  in  32  PC of the resolved branch.
- upd_gidx  in  IDX_BITS  fetch_gidx carried with that branch.
- upd_taken  in  1  actual outcome (PCsel).
- taken1  in  1  predictor 1 was correct.
- taken2  in  1  predictor 2 was correct.
- upd_true  in  1  final prediction was correct.
- branch_cnt  out  32  resolved branches counted.
- correct_cnt  out  32  correctly predicted branches counted.

## Operation
- Indexing: pidx = pc[IDX_BITS+1:2]. gidx = pidx ^ zero-extended ghr.
- Fetch path is combinational from current state:
  - predict1 = bim[pidx(fetch_pc)][1].
  - predict2 = gsh[gidx][1].
  - pprediction = chooser[pidx][1] ? predict2 : predict1.
  - fetch_gidx = gidx.
- When fetch_valid = 0: predict1, predict2 and pprediction drive 0. fetch_gidx still drives gidx.
- Counter update: a saturating 2-bit counter increments when taken (saturates at 3) and decrements when not taken (saturates at 0).
- On a clock edge with upd_valid = 1:
  - bim[pidx(upd_pc)] is updated with upd_taken.
  - gsh[upd_gidx] is updated with upd_taken.
  - chooser[pidx(upd_pc)]: if taken2 & !taken1, increment (saturate at 3); if taken1 & !taken2, decrement (saturate at 0); otherwise hold.
  - ghr <= {ghr[GHR_BITS-2:0], upd_taken}.
  - branch_cnt += 1, and correct_cnt += upd_true. Both wrap modulo 2^32.
- upd_valid = 0: no state changes. taken1, taken2, upd_taken and upd_true are ignored.
- Fetch and update may target the same entry in the same cycle. The fetch sees the old value; the new value is visible from the next cycle. There is no bypass.
- All tables are flop arrays so they can be cleared asynchronously.

## Timing
- Reset (async assert, synchronous deassert handled by the top level):
  - All bim, gsh and chooser entries = 2'b01.
  - ghr = 0; branch_cnt = 0; correct_cnt = 0.
  - Outputs while in reset: predict1 = predict2 = pprediction = 0, and fetch_gidx = pidx(fetch_pc).
- Prediction latency is 0 cycles, combinational from fetch_pc.
- Training latency is 1 cycle: the update on edge N is reflected in the outputs after edge N.
- Counters and statistics update on the same edge as the tables.
- Reset asserted mid-operation clears all state immediately, regardless of clk. Any update pending in that cycle is discarded.
- Back-to-back updates every cycle to the same entry must each apply. The second update acts on the value written by the first.

## Test plan
- Reset: release rst_n, fetch_valid = 1, fetch_pc = 0x10C → predict1 = 0, predict2 = 0, pprediction = 0, fetch_gidx = 0x03, branch_cnt = 0.
- Bimodal training: two updates with upd_pc = 0x10C, upd_gidx = 0x03, upd_taken = 1, taken1 = 0, taken2 = 0.
  - After the first: bim[3] = 2, predict1 = 1.
  - After the second: ghr = 6'b000011, fetch_gidx for 0x10C = 0x00.
- Chooser: two updates at 0x10C with taken1 = 0, taken2 = 1 → chooser[3] goes 1→2→3, and pprediction tracks predict2. Then one update with taken1 = 1, taken2 = 1 → chooser holds at 3.
- Saturation: five taken updates at 0x10C → bim[3] = 3. One not-taken → bim[3] = 2, predict1 still 1. Four further not-taken → bim[3] = 0, not below.
- Same-cycle conflict: fetch 0x10C while updating 0x10C taken from bim = 1 → predict1 = 0 in that cycle and 1 in the next.
- Statistics and reset: three updates with upd_true = 1, 0, 1 → branch_cnt = 3, correct_cnt = 2. Drop rst_n between clock edges → counts, ghr and tables clear at once, and predict1 = 0.
